// File: rtl/regfile_seq_ctrl.sv
// 4x4-bit register file driven by a strobed two-nibble command sequencer.
// Supports write, read, block clear and an auto-scanning display mode.
module regfile_seq_ctrl #(
    parameter int unsigned SCAN_DIV = 8,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CLEAR,
        ST_SCAN
    } state_t;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_SCAN  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [7:0] LP_TIMEOUT  = 8'(TIMEOUT);
    localparam logic [7:0] LP_DIV_LAST = 8'(SCAN_DIV - 1);

    logic       w_clk;
    logic       w_rst;
    logic       w_stb;
    logic [3:0] w_nib;
    logic       w_hold;
    logic [1:0] w_op;
    logic [1:0] w_hdr_addr;

    assign w_clk      = io_in[0];
    assign w_rst      = io_in[1];
    assign w_stb      = io_in[2];
    assign w_nib      = io_in[6:3];
    assign w_hold     = io_in[7];
    assign w_op       = w_nib[3:2];
    assign w_hdr_addr = w_nib[1:0];

    state_t     r_state;
    logic [3:0] r_mem [0:3];
    logic [1:0] r_disp_addr;
    logic [1:0] r_waddr;
    logic [7:0] r_cnt;
    logic [7:0] r_div;
    logic [1:0] r_clr;

    state_t     w_state_nxt;
    logic [1:0] w_disp_nxt;
    logic [1:0] w_waddr_nxt;
    logic [7:0] w_cnt_nxt;
    logic [7:0] w_div_nxt;
    logic [1:0] w_clr_nxt;
    logic       w_decode;
    logic       w_we;
    logic [1:0] w_wa;
    logic [3:0] w_wd;

    always_comb begin
        w_state_nxt = r_state;
        w_disp_nxt  = r_disp_addr;
        w_waddr_nxt = r_waddr;
        w_cnt_nxt   = r_cnt;
        w_div_nxt   = r_div;
        w_clr_nxt   = r_clr;
        w_decode    = 1'b0;
        w_we        = 1'b0;
        w_wa        = r_waddr;
        w_wd        = w_nib;

        case (r_state)
            ST_IDLE: begin
                w_decode = w_stb;
            end
            ST_WAIT: begin
                w_cnt_nxt = r_cnt + 8'd1;
                if (w_stb) begin
                    w_we        = 1'b1;
                    w_disp_nxt  = r_waddr;
                    w_state_nxt = ST_IDLE;
                end else if (w_cnt_nxt == LP_TIMEOUT) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                // One word per cycle; strobes are dropped until done.
                w_we       = 1'b1;
                w_wa       = r_clr;
                w_wd       = 4'h0;
                w_disp_nxt = r_clr;
                w_clr_nxt  = r_clr + 2'd1;
                if (r_clr == 2'd3) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (w_stb && w_op == OP_SCAN) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_stb) begin
                    w_decode = 1'b1;
                end else if (!w_hold) begin
                    if (r_div == LP_DIV_LAST) begin
                        w_div_nxt  = 8'd0;
                        w_disp_nxt = r_disp_addr + 2'd1;
                    end else begin
                        w_div_nxt = r_div + 8'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_decode) begin
            case (w_op)
                OP_WRITE: begin
                    w_waddr_nxt = w_hdr_addr;
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = ST_WAIT;
                end
                OP_READ: begin
                    w_disp_nxt  = w_hdr_addr;
                    w_state_nxt = ST_IDLE;
                end
                OP_SCAN: begin
                    w_disp_nxt  = w_hdr_addr;
                    w_div_nxt   = 8'd0;
                    w_state_nxt = ST_SCAN;
                end
                default: begin
                    w_clr_nxt   = 2'd0;
                    w_state_nxt = ST_CLEAR;
                end
            endcase
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_state     <= ST_IDLE;
            r_disp_addr <= 2'd0;
            r_waddr     <= 2'd0;
            r_cnt       <= 8'd0;
            r_div       <= 8'd0;
            r_clr       <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                r_mem[i] <= 4'h0;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_disp_addr <= w_disp_nxt;
            r_waddr     <= w_waddr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_div       <= w_div_nxt;
            r_clr       <= w_clr_nxt;
            if (w_we) begin
                r_mem[w_wa] <= w_wd;
            end
        end
    end

    assign io_out = {
        r_state == ST_SCAN,
        (r_state == ST_WAIT) || (r_state == ST_CLEAR),
        r_disp_addr,
        r_mem[r_disp_addr]
    };

endmodule

// File: doc/regfile_seq_ctrl.md
Name: regfile_seq_ctrl

Overview:
- Self-contained 4-word x 4-bit register file with a command sequencer, sized for one TinyTapeout 8-in/8-out tile.
- A two-nibble strobed command protocol replaces the raw write-enable/address pins of a bare register file.
- Adds single read, block clear and an auto-scan display mode that cycles the four words on the outputs.
- Pin-limited front end: every port lives on the io_in/io_out bundles.

Parameters:
- SCAN_DIV, 8: clock cycles each word is displayed in SCAN; legal range 1..255.
- TIMEOUT, 15: cycles WAIT_DATA waits for the data nibble before aborting; legal range 1..255.

Ports:
- io_in[0]  input  1  clk; all state updates on rising edge.
- io_in[1]  input  1  rst; synchronous, active-high.
- io_in[2]  input  1  stb; one nibble is presented per cycle while high.
- io_in[6:3]  input  4  nib; header or data nibble.
- io_in[7]  input  1  hold; freezes the scan divider.
- io_out[3:0]  output  4  disp_data; equals mem[disp_addr], combinational from registers.
- io_out[5:4]  output  2  disp_addr; registered.
- io_out[6]  output  1  busy; high in WAIT_DATA or CLEAR.
- io_out[7]  output  1  scan_active; high in SCAN.

Behaviour:
- Reset (rst=1 at an edge): mem[0..3]=0, state=IDLE, disp_addr=0, timers=0, so io_out=8'h00 on the next cycle. Reset overrides any operation in progress; partial CLEAR or pending WRITE is discarded.
- Header nibble: nib[3:2]=op, nib[1:0]=addr. op 00=WRITE, 01=READ, 10=SCAN_TOGGLE, 11=CLEAR.
- IDLE, stb=1, decoded on the same edge:
  - WRITE: latch addr, go to WAIT_DATA, timeout counter=0.
  - READ: disp_addr<=addr; data visible 1 cycle after the strobe cycle.
  - SCAN_TOGGLE: disp_addr<=addr, divider=0, go to SCAN.
  - CLEAR: clear index=0, go to CLEAR.
- WAIT_DATA:
  - stb=1: mem[addr]<=nib and disp_addr<=addr on the same edge, go to IDLE; written value visible next cycle.
  - stb=0: counter increments. On reaching TIMEOUT, go to IDLE with no write; disp_addr unchanged.
  - Data arriving on the same cycle the counter reaches TIMEOUT is accepted (write wins).
- CLEAR: cycle k (k=0..3) writes mem[k]<=0 and sets disp_addr<=k; go to IDLE after k=3 (4 cycles). stb is ignored and dropped; busy=1 throughout.
- SCAN:
  - When hold=0 the divider increments; on reaching SCAN_DIV-1 it wraps to 0 and disp_addr<=disp_addr+1 mod 4 (3 wraps to 0).
  - hold=1 freezes the divider and the address; display stays live.
  - stb with op=SCAN_TOGGLE: go to IDLE, disp_addr keeps its current value, header addr field ignored.
  - stb with any other op: leave SCAN and decode exactly as in IDLE on the same edge.
- Display is always live: a write to the displayed word shows on the next cycle.
- busy and scan_active are decoded from registered state only; no glitches from inputs.
- Only one write can occur per cycle: WAIT_DATA data and CLEAR are mutually exclusive states, so the storage needs no write arbitration.
- Unused encodings: none. All 4 ops are defined and all states are reachable; any illegal state encoding recovers to IDLE.

Test Plan:
- Reset then idle: after rst, io_out=8'h00. Hold stb=0 for 20 cycles -> io_out remains 8'h00.
- Write/read: stb with nib=4'b0010 (WRITE a2), next cycle stb with nib=4'hA -> busy=1 for 1 cycle, then io_out[5:0]=6'b10_1010. READ a0 (nib=4'b0100) -> io_out[5:0]=6'b00_0000 one cycle after the strobe.
- Timeout: header WRITE a1 then no stb for 15 cycles -> busy drops exactly on cycle 15 and mem[1] is unchanged (READ a1 returns 0). Repeat with data arriving on cycle 15 -> write accepted.
- CLEAR: preload mem={1,2,3,4}, send nib=4'b1100 -> busy=1 for 4 cycles, disp_addr steps 0,1,2,3, and a stb issued mid-clear is dropped. Afterwards READ of each word returns 0.
- Scan with SCAN_DIV=8: preload {5,6,7,8}, send nib=4'b1011 (start at a3) -> disp sequence 8,5,6,7 with each value held exactly 8 cycles. hold=1 for 10 cycles freezes the display; a second SCAN_TOGGLE makes scan_active=0 and leaves the address in place.
- Reset mid-operation: rst asserted during CLEAR at k=1 -> all words 0, IDLE state. rst during WAIT_DATA followed by a data nibble -> no write, busy=0.
